mesh_seq_ctrl: RTL

MESH_SEQ_CTRL -- requirements
Module: mesh_seq_ctrl

---
 rtl/mesh_seq_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mesh_seq_ctrl.sv
// mesh_seq_ctrl: sequencer for a ROWS x COLS weight-stationary mesh.
// A job runs IDLE -> LOAD -> XPROP -> ACC -> CAPT -> DONE -> IDLE.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   start, x_in_flat    : one-cycle job request; activation vector sampled with it
//   w_valid/w_ready/w_data : weight stream, ROWS*COLS words, row-major
//   cfg_valid/addr/data : registered weight broadcast to the mesh, addr = {row, col}
//   x_vector_flat       : activation drive, non-zero only during XPROP
//   global_state        : mesh phase (1 = XPROP, 2 = ACC, 0 otherwise)
//   result_flat         : mesh row results, captured at the end of CAPT
//   res_valid/res_ready/res_data : result handshake, held in DONE until taken
//   busy                : sequencer is not idle
module mesh_seq_ctrl #(
  parameter int DW    = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ROW_W = 2,
  parameter int COL_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [COLS*DW-1:0]       x_in_flat,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [DW-1:0]            w_data,
  output logic                     cfg_valid,
  output logic [ROW_W+COL_W-1:0]   cfg_addr,
  output logic [DW-1:0]            cfg_data,
  output logic [COLS*DW-1:0]       x_vector_flat,
  output logic [1:0]               global_state,
  input  logic [ROWS*2*DW-1:0]     result_flat,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ROWS*2*DW-1:0]     res_data,
  output logic                     busy
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_MAX = max3(ROWS, COLS, ROWS * COLS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XPROP,
    S_ACC,
    S_CAPT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [COLS*DW-1:0]       x_q, x_d;
  logic [CNT_W-1:0]         row_q, row_d;
  logic [CNT_W-1:0]         col_q, col_d;
  logic [CNT_W-1:0]         ph_q, ph_d;
  logic                     cfg_valid_q, cfg_valid_d;
  logic [ROW_W+COL_W-1:0]   cfg_addr_q, cfg_addr_d;
  logic [DW-1:0]            cfg_data_q, cfg_data_d;
  logic                     res_valid_q, res_valid_d;
  logic [ROWS*2*DW-1:0]     res_data_q, res_data_d;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    row_d       = row_q;
    col_d       = col_q;
    ph_d        = ph_q;
    cfg_valid_d = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          x_d     = x_in_flat;
          row_d   = '0;
          col_d   = '0;
          ph_d    = '0;
        end
      end
      S_LOAD: begin
        if (w_valid) begin
          cfg_valid_d = 1'b1;
          cfg_addr_d  = {ROW_W'(row_q), COL_W'(col_q)};
          cfg_data_d  = w_data;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              // last word: its cfg pulse lands in the first XPROP cycle
              row_d   = '0;
              ph_d    = '0;
              state_d = S_XPROP;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_XPROP: begin
        if (ph_q == ROW_LAST) begin
          ph_d    = '0;
          state_d = S_ACC;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_ACC: begin
        if (ph_q == COL_LAST) begin
          ph_d    = '0;
          state_d = S_CAPT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_CAPT: begin
        res_data_d  = result_flat;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ph_q        <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ph_q        <= ph_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    w_ready       = (state_q == S_LOAD);
    busy          = (state_q != S_IDLE);
    global_state  = 2'd0;
    x_vector_flat = '0;
    if (state_q == S_XPROP) begin
      global_state  = 2'd1;
      x_vector_flat = x_q;
    end else if (state_q == S_ACC) begin
      global_state = 2'd2;
    end
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
